toy_bus_age_arb_n: RTL and testbench

- Parametrised N-input to 1-output age-matrix arbiter for the toy bus. It is the successor to the fixed 2-input ack arbiter.
- Adds four things: configurable input count and payload widths, a grant lock that holds the winner while the output is back-pressured, an optional one-entry forward register slice, and a one-hot grant output.
- Sits at each bus node merge point, on both the request and ack networks.

---
 rtl/toy_bus_age_arb_n.sv | 175 +++++++++++++++++
 tb/tb_toy_bus_age_arb_n.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_age_arb_n.sv
// N-input age-matrix arbiter for toy bus merge points: oldest valid channel wins,
// optional grant lock under back-pressure and optional one-entry forward slice.
module toy_bus_age_arb_n #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned LOCK_EN = 1,
  parameter int unsigned FORWARD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_vld,
  output logic [NUM_IN-1:0]        in_rdy,
  input  logic [NUM_IN-1:0]        in_opcode,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN*ID_W-1:0]   in_src_id,
  input  logic [NUM_IN*ID_W-1:0]   in_tgt_id,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     out_opcode,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_src_id,
  output logic [ID_W-1:0]          out_tgt_id,
  output logic [NUM_IN-1:0]        out_grant
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  // age[i][j] = 1 : channel j is older than channel i
  logic [NUM_IN-1:0] age [NUM_IN];
  logic [NUM_IN-1:0] sel;
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] hs;
  logic              slot_free;

  logic              mux_opcode;
  logic [DATA_W-1:0] mux_data;
  logic [ID_W-1:0]   mux_src_id;
  logic [ID_W-1:0]   mux_tgt_id;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      sel[i] = in_vld[i] & ~(|(age[i] & in_vld));
    end
  end

  assign in_rdy = grant & {NUM_IN{slot_free}};
  assign hs     = in_rdy & in_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        for (int unsigned j = 0; j < NUM_IN; j++) begin
          age[i][j] <= (j < i);
        end
      end
    end else if (|hs) begin
      // handshaking channel becomes youngest: its row sets, its column clears
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        for (int unsigned j = 0; j < NUM_IN; j++) begin
          if (i != j) begin
            if (hs[i]) begin
              age[i][j] <= 1'b1;
            end else if (hs[j]) begin
              age[i][j] <= 1'b0;
            end
          end
        end
      end
    end
  end

  generate
    if (LOCK_EN != 0) begin : g_lock
      logic             lk_vld;
      logic [IDX_W-1:0] lk_idx;
      logic [IDX_W-1:0] grant_idx;

      // a lock whose channel has dropped valid is ignored, so sel takes over this cycle
      always_comb begin
        grant = sel;
        if (lk_vld && in_vld[lk_idx]) begin
          grant         = '0;
          grant[lk_idx] = 1'b1;
        end
      end

      always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          if (grant[i]) begin
            grant_idx = IDX_W'(i);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lk_vld <= 1'b0;
          lk_idx <= '0;
        end else begin
          lk_vld <= |(grant & in_vld & ~in_rdy);
          lk_idx <= grant_idx;
        end
      end
    end else begin : g_nolock
      always_comb begin
        grant = sel;
      end
    end
  endgenerate

  always_comb begin
    mux_opcode = 1'b0;
    mux_data   = '0;
    mux_src_id = '0;
    mux_tgt_id = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      mux_opcode = mux_opcode | (in_opcode[i] & grant[i]);
      mux_data   = mux_data   | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      mux_src_id = mux_src_id | (in_src_id[i*ID_W +: ID_W] & {ID_W{grant[i]}});
      mux_tgt_id = mux_tgt_id | (in_tgt_id[i*ID_W +: ID_W] & {ID_W{grant[i]}});
    end
  end

  generate
    if (FORWARD != 0) begin : g_fwd
      logic              reg_vld;
      logic              reg_opcode;
      logic [DATA_W-1:0] reg_data;
      logic [ID_W-1:0]   reg_src_id;
      logic [ID_W-1:0]   reg_tgt_id;
      logic [NUM_IN-1:0] reg_grant;

      assign slot_free = ~reg_vld | out_rdy;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_vld    <= 1'b0;
          reg_opcode <= 1'b0;
          reg_data   <= '0;
          reg_src_id <= '0;
          reg_tgt_id <= '0;
          reg_grant  <= '0;
        end else if (|hs) begin
          reg_vld    <= 1'b1;
          reg_opcode <= mux_opcode;
          reg_data   <= mux_data;
          reg_src_id <= mux_src_id;
          reg_tgt_id <= mux_tgt_id;
          reg_grant  <= grant;
        end else if (out_rdy) begin
          reg_vld    <= 1'b0;
        end
      end

      assign out_vld    = reg_vld;
      assign out_opcode = reg_opcode;
      assign out_data   = reg_data;
      assign out_src_id = reg_src_id;
      assign out_tgt_id = reg_tgt_id;
      assign out_grant  = reg_grant & {NUM_IN{reg_vld}};
    end else begin : g_pass
      assign slot_free  = out_rdy;
      assign out_vld    = |in_vld;
      assign out_opcode = mux_opcode;
      assign out_data   = mux_data;
      assign out_src_id = mux_src_id;
      assign out_tgt_id = mux_tgt_id;
      assign out_grant  = grant;
    end
  endgenerate

endmodule

// File: tb/tb_toy_bus_age_arb_n.sv
// Directed bench for toy_bus_age_arb_n: three instances (locked pass-through,
// unlocked pass-through, locked forward slice) driven from one vector table.
module tb_toy_bus_age_arb_n;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   vld [3];
  logic         rdy [3];
  logic [23:0]  tag;
  logic [3:0]   in_opcode;
  logic [127:0] in_data;
  logic [15:0]  in_src_id;
  logic [15:0]  in_tgt_id;

  logic [3:0]   ordy  [3];
  logic         ovld  [3];
  logic         oop   [3];
  logic [31:0]  odata [3];
  logic [3:0]   osrc  [3];
  logic [3:0]   otgt  [3];
  logic [3:0]   ogrant[3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign in_opcode = 4'b1010;
  assign in_src_id = {4'd3, 4'd2, 4'd1, 4'd0};
  assign in_tgt_id = {4'd12, 4'd13, 4'd14, 4'd15};
  always_comb begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = {tag, 8'(i)};
  end

  toy_bus_age_arb_n #(.NUM_IN(4), .DATA_W(32), .ID_W(4), .LOCK_EN(1), .FORWARD(0)) u_lock (
    .clk(clk), .rst_n(rst_n), .in_vld(vld[0]), .in_rdy(ordy[0]), .in_opcode(in_opcode),
    .in_data(in_data), .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .out_vld(ovld[0]),
    .out_rdy(rdy[0]), .out_opcode(oop[0]), .out_data(odata[0]), .out_src_id(osrc[0]),
    .out_tgt_id(otgt[0]), .out_grant(ogrant[0]));

  toy_bus_age_arb_n #(.NUM_IN(4), .DATA_W(32), .ID_W(4), .LOCK_EN(0), .FORWARD(0)) u_nolock (
    .clk(clk), .rst_n(rst_n), .in_vld(vld[1]), .in_rdy(ordy[1]), .in_opcode(in_opcode),
    .in_data(in_data), .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .out_vld(ovld[1]),
    .out_rdy(rdy[1]), .out_opcode(oop[1]), .out_data(odata[1]), .out_src_id(osrc[1]),
    .out_tgt_id(otgt[1]), .out_grant(ogrant[1]));

  toy_bus_age_arb_n #(.NUM_IN(4), .DATA_W(32), .ID_W(4), .LOCK_EN(1), .FORWARD(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_vld(vld[2]), .in_rdy(ordy[2]), .in_opcode(in_opcode),
    .in_data(in_data), .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .out_vld(ovld[2]),
    .out_rdy(rdy[2]), .out_opcode(oop[2]), .out_data(odata[2]), .out_src_id(osrc[2]),
    .out_tgt_id(otgt[2]), .out_grant(ogrant[2]));

  typedef struct {
    int       dut;
    bit       rst;
    bit [3:0] vld;
    bit       rdy;
    int       tag;
    bit       e_vld;
    bit [3:0] e_grant;
    bit [3:0] e_rdy;
    int       e_tag;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int dut, bit rst, bit [3:0] v, bit r, int t,
                              bit ev, bit [3:0] eg, bit [3:0] er, int et);
    tbl.push_back('{dut, rst, v, r, t, ev, eg, er, et});
  endfunction

  function automatic int idx_of(bit [3:0] oh);
    int k = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) k = i;
    return k;
  endfunction

  task automatic check(input string name, input int d, input bit ev, input bit [3:0] eg,
                       input bit [3:0] er, input int et);
    int       k;
    bit       ok;
    bit [31:0] edata;
    k     = idx_of(eg);
    edata = {24'(et), 8'(k)};
    ok    = (ovld[d] == ev) && (ogrant[d] == eg) && (ordy[d] == er);
    if (ev) begin
      ok = ok && (odata[d] == edata) && (oop[d] == 1'(k % 2)) &&
           (osrc[d] == 4'(k)) && (otgt[d] == 4'(15 - k));
    end else if (d < 2) begin
      edata = '0;
      ok = ok && (odata[d] == 32'h0) && (oop[d] == 1'b0) && (osrc[d] == 4'h0) && (otgt[d] == 4'h0);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s dut%0d: got vld=%b grant=%b in_rdy=%b data=%h op=%b src=%h tgt=%h, want vld=%b grant=%b in_rdy=%b data=%h",
               name, d, ovld[d], ogrant[d], ordy[d], odata[d], oop[d], osrc[d], otgt[d],
               ev, eg, er, edata);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    if (v.rst) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    for (int d = 0; d < 3; d++) begin
      vld[d] = 4'b0000;
      rdy[d] = 1'b0;
    end
    vld[v.dut] = v.vld;
    rdy[v.dut] = v.rdy;
    tag        = 24'(v.tag);
    #5;
    check($sformatf("vec%0d", n), v.dut, v.e_vld, v.e_grant, v.e_rdy, v.e_tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      vld[d] = 4'b0000;
      rdy[d] = 1'b0;
    end
    tag = '0;

    // locked pass-through: round robin, youngest-loses, lock hold, lock drop
    add(0, 1, 4'b0000, 1, 1,  0, 4'b0000, 4'b0000, 1);
    add(0, 0, 4'b1111, 1, 2,  1, 4'b0001, 4'b0001, 2);
    add(0, 0, 4'b1111, 1, 3,  1, 4'b0010, 4'b0010, 3);
    add(0, 0, 4'b1111, 1, 4,  1, 4'b0100, 4'b0100, 4);
    add(0, 0, 4'b1111, 1, 5,  1, 4'b1000, 4'b1000, 5);
    add(0, 0, 4'b1111, 1, 6,  1, 4'b0001, 4'b0001, 6);
    add(0, 0, 4'b1111, 1, 7,  1, 4'b0010, 4'b0010, 7);
    add(0, 0, 4'b0100, 1, 8,  1, 4'b0100, 4'b0100, 8);
    add(0, 0, 4'b0100, 1, 9,  1, 4'b0100, 4'b0100, 9);
    add(0, 0, 4'b0100, 1, 10, 1, 4'b0100, 4'b0100, 10);
    add(0, 0, 4'b0110, 1, 11, 1, 4'b0010, 4'b0010, 11);
    add(0, 0, 4'b0110, 1, 12, 1, 4'b0100, 4'b0100, 12);
    add(0, 0, 4'b0001, 0, 13, 1, 4'b0001, 4'b0000, 13);
    for (int i = 0; i < 4; i++) add(0, 0, 4'b0011, 0, 13, 1, 4'b0001, 4'b0000, 13);
    add(0, 0, 4'b0011, 1, 13, 1, 4'b0001, 4'b0001, 13);
    add(0, 0, 4'b0010, 1, 14, 1, 4'b0010, 4'b0010, 14);
    add(0, 0, 4'b0010, 0, 15, 1, 4'b0010, 4'b0000, 15);
    add(0, 0, 4'b0011, 0, 15, 1, 4'b0010, 4'b0000, 15);
    add(0, 0, 4'b0011, 1, 15, 1, 4'b0010, 4'b0010, 15);
    add(0, 0, 4'b0100, 0, 16, 1, 4'b0100, 4'b0000, 16);
    add(0, 0, 4'b1000, 0, 17, 1, 4'b1000, 4'b0000, 17);
    add(0, 0, 4'b1000, 1, 17, 1, 4'b1000, 4'b1000, 17);
    add(0, 0, 4'b1111, 1, 18, 1, 4'b0100, 4'b0100, 18);
    add(0, 0, 4'b0000, 1, 19, 0, 4'b0000, 4'b0000, 19);

    // unlocked pass-through: same back-pressure stimulus, then re-arbitration
    add(1, 1, 4'b0001, 0, 20, 1, 4'b0001, 4'b0000, 20);
    for (int i = 0; i < 4; i++) add(1, 0, 4'b0011, 0, 20, 1, 4'b0001, 4'b0000, 20);
    add(1, 0, 4'b0011, 1, 20, 1, 4'b0001, 4'b0001, 20);
    add(1, 0, 4'b0010, 1, 21, 1, 4'b0010, 4'b0010, 21);
    add(1, 0, 4'b0010, 0, 22, 1, 4'b0010, 4'b0000, 22);
    add(1, 0, 4'b0011, 0, 22, 1, 4'b0001, 4'b0000, 22);
    add(1, 0, 4'b0011, 1, 23, 1, 4'b0001, 4'b0001, 23);

    // forward slice: out_rdy 1,0,1,1 with all channels valid, then drain
    add(2, 1, 4'b1111, 1, 30, 0, 4'b0000, 4'b0001, 30);
    add(2, 0, 4'b1111, 0, 31, 1, 4'b0001, 4'b0000, 30);
    add(2, 0, 4'b1111, 1, 32, 1, 4'b0001, 4'b0010, 30);
    add(2, 0, 4'b1111, 1, 33, 1, 4'b0010, 4'b0100, 32);
    add(2, 0, 4'b0000, 1, 34, 1, 4'b0100, 4'b0000, 33);
    add(2, 0, 4'b0000, 1, 35, 0, 4'b0000, 4'b0000, 35);
    add(2, 0, 4'b1111, 0, 36, 0, 4'b0000, 4'b1000, 36);
    add(2, 0, 4'b1111, 0, 37, 1, 4'b1000, 4'b0000, 36);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    // slice full and lock moved to channel 1, then asynchronous reset mid-cycle
    vld[2] = 4'b0010;
    rdy[2] = 1'b0;
    tag    = 24'd38;
    @(posedge clk);
    #1;
    vld[2] = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ovld[2] !== 1'b0 || ogrant[2] !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: got vld=%b grant=%b, want vld=0 grant=0000", ovld[2], ogrant[2]);
    end
    #2;
    rst_n  = 1'b1;
    rdy[2] = 1'b1;
    tag    = 24'd40;
    #1;
    check("post_reset_grant", 2, 0, 4'b0000, 4'b0001, 40);
    @(posedge clk);
    #1;
    check("post_reset_beat", 2, 1, 4'b0001, 4'b0010, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
